pbkdf2_hmac_seq: RTL and testbench

Initiator side of the hmac_sha256_32_132 request interface. Given a 256-bit key and a 128-byte salt block, it runs PBKDF2-HMAC-SHA256 with one iteration. For each block index i = 1..NUM_BLOCKS it builds the 132-byte message salt || INT(i), pulses the HMAC enable and captures the returned hash. The concatenated derived key goes to the scrypt top level: the final PBKDF2 stage uses NUM_BLOCKS=1, and the bench and block-mixing stages use 4.

---
 rtl/pbkdf2_hmac_seq.sv | 174 +++++++++++++++++
 tb/tb_pbkdf2_hmac_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbkdf2_hmac_seq.sv
// PBKDF2-HMAC-SHA256 sequencer, single iteration.
// Drives the request side of an HMAC-SHA256 core with a 32-byte key and a
// 132-byte message (128-byte salt followed by a big-endian 32-bit block index).
// It issues one request per output block and concatenates the returned hashes
// into the derived key dk. Block j of dk (index i = j+1) lives at dk[256*j +: 256].
module pbkdf2_hmac_seq #(
    parameter int NUM_BLOCKS = 4,    // 256-bit output blocks, 1..255
    parameter int TIMEOUT    = 1024  // cycles allowed per HMAC response, >= 2
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic [255:0]              key,
    input  logic [1023:0]             salt,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [256*NUM_BLOCKS-1:0] dk,
    output logic                      hmac_enable,
    output logic [255:0]              hmac_data,
    output logic [1055:0]             hmac_msg,
    input  logic [255:0]              hmac_hash,
    input  logic                      hmac_hash_done
);

    localparam int             TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]     BLK_LAST = 8'(NUM_BLOCKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN,
        S_FAIL
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [7:0]                r_blk;      // current block index i (1-based)
    logic [TMO_W-1:0]          r_tmo;      // cycles spent in WAIT for this block
    logic [255:0]              r_key;
    logic [1055:0]             r_msg;
    logic [256*NUM_BLOCKS-1:0] r_dk;

    logic                      w_hit;      // HMAC result accepted this cycle
    logic                      w_last;     // current block is the final one
    logic                      w_expired;  // response budget used up
    logic [7:0]                w_blk_next;

    // The hash-done input is only meaningful while waiting; a level left over
    // from the previous block is deliberately invisible in ISSUE.
    assign w_hit      = (r_state == S_WAIT) && hmac_hash_done;
    assign w_last     = (r_blk == BLK_LAST);
    assign w_expired  = (r_tmo == TMO_LAST);
    assign w_blk_next = r_blk + 8'd1;

    assign dk        = r_dk;
    assign hmac_data = r_key;
    assign hmac_msg  = r_msg;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore outputs; done/error/enable are decoded from the state
    // so each is exactly one cycle wide.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        hmac_enable  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy         = 1'b1;
                hmac_enable  = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A result arriving on the expiry cycle still counts.
                if (hmac_hash_done) begin
                    w_next_state = w_last ? S_FIN : S_ISSUE;
                end else if (w_expired) begin
                    w_next_state = S_FAIL;
                end
            end
            S_FIN: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_FAIL: begin
                error        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Key and message registers: loaded on an accepted start, index field
    // advanced when a block completes so the next ISSUE sees a settled message.
    // NOTE: these wide data registers are reset on purpose because the outputs
    // they drive must read all-zero during reset; plain data pipelines that no
    // one observes in reset would not need it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_key <= '0;
            r_msg <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_key <= key;
            // Bytes 128..131 hold the big-endian index; i=1 puts 0x01 in byte 131.
            r_msg <= {8'd1, 24'd0, salt};
        end else if (w_hit && !w_last) begin
            r_msg[1055:1024] <= {w_blk_next, 24'd0};
        end
    end

    // Block index: starts at 1 on accept, steps after each non-final capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_blk <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_blk <= 8'd1;
        end else if (w_hit && !w_last) begin
            r_blk <= w_blk_next;
        end
    end

    // Response timer: cleared in ISSUE, counts WAIT cycles, saturates at its limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo <= '0;
        end else if ((r_state == S_WAIT) && !hmac_hash_done && !w_expired) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Derived key: cleared on accept, block i-1 written when its hash returns,
    // held otherwise so the result stays readable after done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dk <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_dk <= '0;
        end else if (w_hit) begin
            for (int j = 0; j < NUM_BLOCKS; j++) begin
                if (r_blk == 8'(j + 1)) begin
                    r_dk[256*j +: 256] <= hmac_hash;
                end
            end
        end
    end

endmodule

// File: tb/tb_pbkdf2_hmac_seq.sv
// Directed bench for pbkdf2_hmac_seq: a 4-block instance (TIMEOUT=16) and a
// 1-block instance, each driven by a small HMAC mock that answers with
// {32{i}} where i is the low byte of the block index in the request.
module tb_pbkdf2_hmac_seq;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- 4-block instance ----------------
    logic          start = 1'b0;
    logic [255:0]  key   = '0;
    logic [1023:0] salt  = '0;
    logic          busy, done, error, hmac_enable;
    logic [1023:0] dk;
    logic [255:0]  hmac_data;
    logic [1055:0] hmac_msg;
    logic [255:0]  hmac_hash      = '0;
    logic          hmac_hash_done = 1'b0;

    pbkdf2_hmac_seq #(.NUM_BLOCKS(4), .TIMEOUT(16)) u_dut4 (
        .clk(clk), .n_rst(n_rst), .start(start), .key(key), .salt(salt),
        .busy(busy), .done(done), .error(error), .dk(dk),
        .hmac_enable(hmac_enable), .hmac_data(hmac_data), .hmac_msg(hmac_msg),
        .hmac_hash(hmac_hash), .hmac_hash_done(hmac_hash_done)
    );

    // ---------------- 1-block instance ----------------
    logic          start_1 = 1'b0;
    logic [255:0]  key_1   = '0;
    logic [1023:0] salt_1  = '0;
    logic          busy_1, done_1, error_1, hmac_enable_1;
    logic [255:0]  dk_1;
    logic [255:0]  hmac_data_1;
    logic [1055:0] hmac_msg_1;
    logic [255:0]  hmac_hash_1      = '0;
    logic          hmac_hash_done_1 = 1'b0;

    pbkdf2_hmac_seq #(.NUM_BLOCKS(1), .TIMEOUT(1024)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .start(start_1), .key(key_1), .salt(salt_1),
        .busy(busy_1), .done(done_1), .error(error_1), .dk(dk_1),
        .hmac_enable(hmac_enable_1), .hmac_data(hmac_data_1), .hmac_msg(hmac_msg_1),
        .hmac_hash(hmac_hash_1), .hmac_hash_done(hmac_hash_done_1)
    );

    // Mock mode: 0 = pulse 5 cycles after enable, 1 = level-high for 3 cycles
    // starting in the enable cycle, 2 = never answer.
    int mock_mode = 0;
    int m_cnt = 0, m_hold = 0;
    int en_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic done_busy = 1'b0;
    logic [31:0]   cap_ctr  [0:63];
    logic [1023:0] cap_salt [0:63];
    logic [255:0]  cap_key  [0:63];

    // Mock HMAC core and event monitor for the 4-block instance.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_busy = busy;
        end
        if (error) err_cnt++;
        if (!n_rst) begin
            m_cnt = 0;
            m_hold = 0;
            hmac_hash_done = 1'b0;
        end else begin
            hmac_hash_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) hmac_hash_done = 1'b1;
            end
            if (m_hold != 0) begin
                m_hold--;
                hmac_hash_done = 1'b1;
            end
            if (hmac_enable) begin
                if (en_cnt < 64) begin
                    cap_ctr[en_cnt]  = hmac_msg[1055:1024];
                    cap_salt[en_cnt] = hmac_msg[1023:0];
                    cap_key[en_cnt]  = hmac_data;
                end
                en_cnt++;
                hmac_hash = {32{hmac_msg[1055:1048]}};
                if (mock_mode == 0) begin
                    m_cnt = 5;
                end else if (mock_mode == 1) begin
                    hmac_hash_done = 1'b1;
                    m_hold = 2;
                end
            end
        end
    end

    int m1_cnt = 0, en1_cnt = 0, done1_cnt = 0;

    // Mock HMAC core for the 1-block instance (always the 5-cycle pulse).
    always @(negedge clk) begin
        if (done_1) done1_cnt++;
        if (!n_rst) begin
            m1_cnt = 0;
            hmac_hash_done_1 = 1'b0;
        end else begin
            hmac_hash_done_1 = 1'b0;
            if (m1_cnt != 0) begin
                m1_cnt--;
                if (m1_cnt == 0) hmac_hash_done_1 = 1'b1;
            end
            if (hmac_enable_1) begin
                en1_cnt++;
                hmac_hash_1 = {32{hmac_msg_1[1055:1048]}};
                m1_cnt = 5;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wide compare; on a miss reports the first differing 32-bit word.
    task automatic check_wide(input string tag, input logic [1055:0] obs, input logic [1055:0] exp);
        int first;
        first = -1;
        for (int w = 32; w >= 0; w--) begin
            if (obs[32*w +: 32] !== exp[32*w +: 32]) first = w;
        end
        checks++;
        assert (obs === exp) else begin
            failures++;
            if (first < 0) first = 0;
            $error("FAIL %s word=%0d observed=%h expected=%h", tag, first,
                   obs[32*first +: 32], exp[32*first +: 32]);
        end
    endtask

    // One full 4-block run; optionally hammers start (with different inputs)
    // while busy. Returns in IDLE, one cycle after the done pulse.
    task automatic run4(input string tag, input logic [255:0] k, input logic [1023:0] s,
                        input bit spam);
        int cyc;
        key   = k;
        salt  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        if (spam) begin
            key  = ~k;
            salt = ~s;
        end
        cyc = 0;
        while (!done && !error && cyc < 200) begin
            start = spam && busy;
            step();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done"}, 256'(done), 256'(1'b1));
        check({tag, "_busy_at_done"}, 256'(busy), 256'(1'b0));
        step();
        key  = k;
        salt = s;
    endtask

    logic [1023:0] exp_dk4;
    logic [31:0]   exp_ctr [0:3];
    logic [255:0]  k_ones, k_a5, k_77, k_5a;
    logic [1023:0] s_ones, s_3c, s_c3;
    int base, d0, e0, n;

    initial begin
        exp_dk4 = {{32{8'h04}}, {32{8'h03}}, {32{8'h02}}, {32{8'h01}}};
        exp_ctr[0] = 32'h0100_0000;
        exp_ctr[1] = 32'h0200_0000;
        exp_ctr[2] = 32'h0300_0000;
        exp_ctr[3] = 32'h0400_0000;
        k_ones = {32{8'h01}};
        k_a5   = {32{8'hA5}};
        k_77   = {32{8'h77}};
        k_5a   = {32{8'h5A}};
        s_ones = {128{8'h01}};
        s_3c   = {128{8'h3C}};
        s_c3   = {128{8'hC3}};

        // ---- reset state ----
        #2 n_rst = 1'b0;
        #1;
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_done_error_en", 256'({done, error, hmac_enable}), 256'(3'b000));
        check_wide("rst_dk", 1056'(dk), '0);
        check_wide("rst_msg", hmac_msg, '0);
        check("rst_data", hmac_data, '0);
        check("rst_nb1_outputs", 256'({busy_1, done_1, error_1, hmac_enable_1}), 256'(4'b0));
        step();
        step();
        n_rst = 1'b1;
        step();

        // ---- test 1: basic 4-block run, 5-cycle mock ----
        mock_mode = 0;
        base = en_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        run4("t1", k_ones, s_ones, 1'b0);
        check("t1_enables", 256'(en_cnt - base), 256'(4));
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t1_ctr%0d", j), 256'(cap_ctr[base + j]), 256'(exp_ctr[j]));
            check_wide($sformatf("t1_salt%0d", j), 1056'(cap_salt[base + j]), 1056'(s_ones));
        end
        check_wide("t1_dk", 1056'(dk), 1056'(exp_dk4));
        step();
        step();
        check_wide("t1_dk_hold", 1056'(dk), 1056'(exp_dk4));
        check("t1_done_count", 256'(done_cnt - d0), 256'(1));
        check("t1_busy_with_done", 256'(done_busy), 256'(1'b0));
        check("t1_no_error", 256'(err_cnt - e0), 256'(0));

        // ---- test 2: back-to-back, lingering done level ----
        mock_mode = 1;
        base = en_cnt;
        d0 = done_cnt;
        run4("t2", k_ones, s_ones, 1'b0);
        check("t2_enables", 256'(en_cnt - base), 256'(4));
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t2_ctr%0d", j), 256'(cap_ctr[base + j]), 256'(exp_ctr[j]));
        end
        check_wide("t2_dk", 1056'(dk), 1056'(exp_dk4));
        step();
        step();
        step();
        check("t2_done_count", 256'(done_cnt - d0), 256'(1));

        // ---- test 3: start spammed while busy with different inputs ----
        mock_mode = 0;
        base = en_cnt;
        d0 = done_cnt;
        run4("t3", k_a5, s_3c, 1'b1);
        check("t3_enables", 256'(en_cnt - base), 256'(4));
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t3_key%0d", j), cap_key[base + j], k_a5);
            check_wide($sformatf("t3_salt%0d", j), 1056'(cap_salt[base + j]), 1056'(s_3c));
        end
        check_wide("t3_dk", 1056'(dk), 1056'(exp_dk4));
        step();
        step();
        check("t3_done_count", 256'(done_cnt - d0), 256'(1));
        check("t3_idle", 256'(busy), 256'(1'b0));

        // ---- test 4: timeout with TIMEOUT=16 ----
        mock_mode = 2;
        d0 = done_cnt;
        e0 = err_cnt;
        key = k_ones;
        salt = s_ones;
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_enable", 256'(hmac_enable), 256'(1'b1));
        @(posedge clk);  // ISSUE -> WAIT edge
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (error) break;
        end
        check("to_latency", 256'(n), 256'(16));
        check("to_error", 256'(error), 256'(1'b1));
        check("to_busy", 256'(busy), 256'(1'b0));
        step();
        step();
        check("to_error_one_cycle", 256'(error), 256'(1'b0));
        check("to_err_count", 256'(err_cnt - e0), 256'(1));
        check("to_no_done", 256'(done_cnt - d0), 256'(0));
        mock_mode = 0;
        run4("to_rerun", k_ones, s_ones, 1'b0);
        check_wide("to_rerun_dk", 1056'(dk), 1056'(exp_dk4));

        // ---- test 5: reset during WAIT of block 2 ----
        mock_mode = 0;
        base = en_cnt;
        key = k_ones;
        salt = s_ones;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while ((en_cnt - base) < 2 && n < 100) begin
            step();
            n++;
        end
        check("rs_reached_blk2", 256'(en_cnt - base), 256'(2));
        step();
        step();
        check("rs_busy_in_wait", 256'(busy), 256'(1'b1));
        check("rs_blk1_captured", dk[255:0], {32{8'h01}});
        d0 = done_cnt;
        e0 = err_cnt;
        n_rst = 1'b0;
        #1;
        check("rs_busy", 256'(busy), 256'(1'b0));
        check("rs_pulses", 256'({done, error, hmac_enable}), 256'(3'b000));
        check_wide("rs_dk", 1056'(dk), '0);
        check_wide("rs_msg", hmac_msg, '0);
        check("rs_data", hmac_data, '0);
        step();
        step();
        step();
        n_rst = 1'b1;
        repeat (10) step();
        check("rs_no_done", 256'(done_cnt - d0), 256'(0));
        check("rs_no_error", 256'(err_cnt - e0), 256'(0));
        base = en_cnt;
        run4("rs_rerun", k_77, s_ones, 1'b0);
        check("rs_rerun_enables", 256'(en_cnt - base), 256'(4));
        check_wide("rs_rerun_dk", 1056'(dk), 1056'(exp_dk4));

        // ---- test 6: NUM_BLOCKS=1 instance ----
        base = en1_cnt;
        d0 = done1_cnt;
        key_1 = k_5a;
        salt_1 = s_c3;
        start_1 = 1'b1;
        step();
        start_1 = 1'b0;
        check("nb1_enable", 256'(hmac_enable_1), 256'(1'b1));
        check("nb1_ctr", 256'(hmac_msg_1[1055:1024]), 256'(32'h0100_0000));
        check_wide("nb1_msg", hmac_msg_1, {32'h0100_0000, s_c3});
        check("nb1_key", hmac_data_1, k_5a);
        n = 0;
        while (!hmac_hash_done_1 && n < 50) begin
            step();
            n++;
        end
        check("nb1_hash_done_seen", 256'(hmac_hash_done_1), 256'(1'b1));
        check("nb1_no_early_done", 256'(done_1), 256'(1'b0));
        step();
        check("nb1_done", 256'(done_1), 256'(1'b1));
        check("nb1_busy_at_done", 256'(busy_1), 256'(1'b0));
        check("nb1_dk", dk_1, {32{8'h01}});
        step();
        step();
        check("nb1_enables", 256'(en1_cnt - base), 256'(1));
        check("nb1_done_count", 256'(done1_cnt - d0), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
